// File: rtl/brick_operand_sequencer_pkg.sv
// Shared constants, state/pass encodings and shift lookup for the
// bit-brick operand sequencer.
package brick_operand_sequencer_pkg;

  localparam int unsigned LANES   = 16;
  localparam int unsigned BRICK_W = 2;
  localparam int unsigned OP_W    = 2 * BRICK_W;
  localparam int unsigned PACK_W  = LANES * BRICK_W;

  localparam logic [3:0] SH0 = 4'd0;
  localparam logic [3:0] SH2 = 4'd2;
  localparam logic [3:0] SH4 = 4'd4;

  typedef enum logic {IDLE, ISSUE} state_t;

  // Pass naming: first letter = activation brick, second = weight brick.
  typedef enum logic [1:0] {P_LL, P_HL, P_LH, P_HH} pass_t;

  function automatic logic [3:0] pass_shift(input pass_t p);
    case (p)
      P_LL:    return SH0;
      P_HH:    return SH4;
      default: return SH2;
    endcase
  endfunction

endpackage

// File: rtl/brick_operand_sequencer_brick_pack.sv
// Selects the low or high brick of every lane of an operand vector
// and packs the selected bricks densely.
module brick_pack
  import brick_operand_sequencer_pkg::*;
#(
  parameter int unsigned N_LANES = LANES,
  parameter int unsigned B_W     = BRICK_W
) (
  input  logic [N_LANES*2*B_W-1:0] vec,
  input  logic                     sel_hi,
  output logic [N_LANES*B_W-1:0]   bricks
);

  always_comb begin
    bricks = '0;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      bricks[k*B_W +: B_W] = sel_hi ? vec[k*2*B_W + B_W +: B_W]
                                    : vec[k*2*B_W +: B_W];
    end
  end

endmodule

// File: rtl/brick_operand_sequencer.sv
// Producer side of the bit-brick PE interface: captures one operand vector
// and issues its brick passes (4 in 4-bit mode, 1 in 2-bit mode).
module brick_operand_sequencer #(
  parameter int unsigned LANES   = 16,
  parameter int unsigned BRICK_W = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [LANES*2*BRICK_W-1:0] i_act_vec,
  input  logic [LANES*2*BRICK_W-1:0] i_wgt_vec,
  input  logic                       i_A_signed,
  input  logic                       i_W_signed,
  input  logic                       i_mode_2b,
  output logic                       o_valid,
  input  logic                       i_out_ready,
  output logic [LANES*BRICK_W-1:0]   o_activation,
  output logic [LANES*BRICK_W-1:0]   o_weight,
  output logic                       o_A_signed,
  output logic                       o_W_signed,
  output logic [3:0]                 o_shift_amount,
  output logic [1:0]                 o_pass_idx,
  output logic                       o_last
);
  import brick_operand_sequencer_pkg::*;

  localparam int unsigned VEC_W = LANES * 2 * BRICK_W;
  localparam int unsigned PK_W  = LANES * BRICK_W;

  state_t             state, state_nxt;
  pass_t              pass_q, pass_nxt;
  logic               load;
  logic [VEC_W-1:0]   cap_act, cap_wgt;
  logic               cap_A, cap_W, cap_mode;
  logic               accept, advance;
  logic [VEC_W-1:0]   src_act, src_wgt;
  logic               src_A, src_W, src_mode;
  logic               act_hi, wgt_hi;
  logic [PK_W-1:0]    act_pk, wgt_pk;
  logic               nxt_A_s, nxt_W_s, nxt_last;
  logic [3:0]         nxt_shift;

  // Accepting on the last-pass handshake keeps back-to-back vectors bubble-free.
  assign o_ready = !i_rst && ((state == IDLE) || (o_last && i_out_ready));
  assign accept  = i_valid && o_ready;
  assign advance = o_valid && i_out_ready;

  // Pass 0 is built straight from the inputs on accept so it appears next cycle.
  assign src_act  = accept ? i_act_vec  : cap_act;
  assign src_wgt  = accept ? i_wgt_vec  : cap_wgt;
  assign src_A    = accept ? i_A_signed : cap_A;
  assign src_W    = accept ? i_W_signed : cap_W;
  assign src_mode = accept ? i_mode_2b  : cap_mode;

  brick_pack #(.N_LANES(LANES), .B_W(BRICK_W)) u_pack_act (
    .vec    (src_act),
    .sel_hi (act_hi),
    .bricks (act_pk)
  );

  brick_pack #(.N_LANES(LANES), .B_W(BRICK_W)) u_pack_wgt (
    .vec    (src_wgt),
    .sel_hi (wgt_hi),
    .bricks (wgt_pk)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= IDLE;
      pass_q         <= P_LL;
      cap_act        <= '0;
      cap_wgt        <= '0;
      cap_A          <= 1'b0;
      cap_W          <= 1'b0;
      cap_mode       <= 1'b0;
      o_valid        <= 1'b0;
      o_activation   <= '0;
      o_weight       <= '0;
      o_A_signed     <= 1'b0;
      o_W_signed     <= 1'b0;
      o_shift_amount <= '0;
      o_pass_idx     <= '0;
      o_last         <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_valid <= (state_nxt == ISSUE);
      if (accept) begin
        cap_act  <= i_act_vec;
        cap_wgt  <= i_wgt_vec;
        cap_A    <= i_A_signed;
        cap_W    <= i_W_signed;
        cap_mode <= i_mode_2b;
      end
      if (load) begin
        pass_q         <= pass_nxt;
        o_activation   <= act_pk;
        o_weight       <= wgt_pk;
        o_A_signed     <= nxt_A_s;
        o_W_signed     <= nxt_W_s;
        o_shift_amount <= nxt_shift;
        o_pass_idx     <= pass_nxt;
        o_last         <= nxt_last;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pass_nxt  = pass_q;
    load      = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (advance && o_last && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      pass_nxt = P_LL;
      load     = 1'b1;
    end else if (advance && !o_last) begin
      load = 1'b1;
      case (pass_q)
        P_LL:    pass_nxt = P_HL;
        P_HL:    pass_nxt = P_LH;
        default: pass_nxt = P_HH;
      endcase
    end
  end

  always_comb begin
    act_hi    = !src_mode && ((pass_nxt == P_HL) || (pass_nxt == P_HH));
    wgt_hi    = !src_mode && ((pass_nxt == P_LH) || (pass_nxt == P_HH));
    nxt_A_s   = src_A && (src_mode || act_hi);
    nxt_W_s   = src_W && (src_mode || wgt_hi);
    nxt_shift = src_mode ? SH0 : pass_shift(pass_nxt);
    nxt_last  = src_mode || (pass_nxt == P_HH);
  end

endmodule

// File: doc/brick_operand_sequencer.md
Name: brick_operand_sequencer

Overview:
- Producer end of the bit-brick PE operand interface.
- Accepts one vector of 16 lanes of 4-bit activation/weight pairs, or 2-bit pairs in 2-bit mode.
- Decomposes each operand into 2-bit bricks and issues one packed 32-bit activation word and one packed 32-bit weight word per pass.
- Drives per-brick signedness flags, a shift amount of 0, 2 or 4, pass index and last-pass marker. A downstream PE plus accumulator rebuilds the full products.

Parameters:
- LANES, 16, number of operand lanes (bricks per packed word).
- BRICK_W, 2, brick width in bits; operand width is 2*BRICK_W = 4.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  input vector valid.
- o_ready  output  1  sequencer can accept a vector this cycle.
- i_act_vec  input  64  lane k activation = bits [4k+3:4k].
- i_wgt_vec  input  64  lane k weight = bits [4k+3:4k].
- i_A_signed  input  1  activations are two's complement.
- i_W_signed  input  1  weights are two's complement.
- i_mode_2b  input  1  1 = 2-bit operands (low brick only), single pass.
- o_valid  output  1  current pass valid.
- i_out_ready  input  1  downstream accepts current pass.
- o_activation  output  32  packed activation bricks, lane k at [2k+1:2k].
- o_weight  output  32  packed weight bricks, lane k at [2k+1:2k].
- o_A_signed  output  1  upper brick of activation in use and activation signed.
- o_W_signed  output  1  upper brick of weight in use and weight signed.
- o_shift_amount  output  4  0, 2 or 4.
- o_pass_idx  output  2  pass number 0..3.
- o_last  output  1  final pass of current vector.

Behaviour:
- Clock/reset: one clock i_clk; asynchronous active-high reset i_rst.
- Reset values: all registered outputs 0, state IDLE. o_ready = 0 while i_rst is high. Reset mid-vector aborts it; no partial passes resume.
- Capture: on i_valid && o_ready, capture vectors, both signed flags and the mode into internal registers. Flags and mode are sampled only at accept.
- States:
  - IDLE: o_valid = 0, o_ready = 1.
  - ISSUE: o_valid = 1; pass counter pc.
- Latency: accept in cycle N gives pass 0 on outputs in cycle N+1. All outputs are registered.
- Pass advance: only when o_valid && i_out_ready. While i_out_ready = 0, every output holds stable.
- 4-bit mode passes (lo = bits[1:0], hi = bits[3:2] of each lane):
  - P0: act lo, wgt lo, shift 0, A_s = 0, W_s = 0.
  - P1: act hi, wgt lo, shift 2, A_s = cap_A, W_s = 0.
  - P2: act lo, wgt hi, shift 2, A_s = 0, W_s = cap_W.
  - P3: act hi, wgt hi, shift 4, A_s = cap_A, W_s = cap_W, o_last = 1.
- 2-bit mode: single pass P0 using the low brick, shift 0, A_s = cap_A, W_s = cap_W, o_last = 1, o_pass_idx = 0.
- o_ready in ISSUE: equals (o_last && i_out_ready). This lets a new vector be accepted in the same cycle the last pass is taken, so the next vector's P0 appears the following cycle with no bubble.
- After the last pass is taken with no new vector: o_valid = 0 next cycle, state IDLE. Data outputs hold their last values.
- Unused bits: o_shift_amount[3] is always 0. Values 1 and 3 are never produced.
- i_valid while o_ready = 0: ignored. The upstream must hold the vector.

Decomposition:
- Shared package:
  - Constants LANES, BRICK_W, OP_W = 4, PACK_W = 32.
  - Shift codes SH0 = 0, SH2 = 2, SH4 = 4.
  - State enum {IDLE, ISSUE}.
  - Pass enum {P_LL, P_HL, P_LH, P_HH}.
- Sub-module brick_pack: combinational. Takes the 64-bit vector and a hi/lo select and returns the 32-bit packed bricks. It is instantiated twice, once for activations and once for weights.

Test Plan:
- Signed 4-bit: lane0 A = 4'b1011, W = 4'b0110, both signed, other lanes 0, i_out_ready = 1.
  - Required passes: P0 act[1:0] = 11, wgt[1:0] = 10, sh 0, flags 00; P1 act = 10, wgt = 10, sh 2, flags 10; P2 act = 11, wgt = 01, sh 2, flags 01; P3 act = 10, wgt = 01, sh 4, flags 11, o_last = 1.
  - A reference accumulation of signed brick products gives 6 − 16 + 12 − 32 = −30 = (−5)(6).
- Unsigned same operands: every pass has flags 00; accumulation gives 11 × 6 = 66.
- 2-bit mode: A = 0x…3, W = 0x…2, signed.
  - Required: one pass, sh 0, flags 11, o_last = 1, o_valid low the next cycle. o_ready stays high in that next cycle so a second vector can be accepted.
- Back-to-back: i_valid held high with two vectors.
  - Required: second accept in the P3 cycle, P0 of vector 2 in the next cycle, and 8 consecutive valid cycles.
- Backpressure: drop i_out_ready for 3 cycles during P1.
  - Required: outputs frozen at the P1 values and o_ready = 0; P2 follows once i_out_ready returns.
- Mid-operation reset: assert i_rst during P2.
  - Required: all outputs 0 immediately, IDLE, o_ready = 1 after release. The next vector starts at P0.
